// File: rtl/gin_debounce_pkg.sv
// Shared definitions for the input-conditioning blocks.
//   state_e            : per-channel debounce FSM encoding
//   DEF_STABLE_CYCLES  : default number of stable synchronized cycles to accept a level
//   DEF_CNT_W          : default per-channel counter width
package gin_debounce_pkg;

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_COUNT  = 1'b1
   } state_e;

   localparam int DEF_STABLE_CYCLES = 4;
   localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/gin_debounce_ch.sv
// Single-channel debouncer: two-flop synchronizer, STABLE/COUNT FSM with
// counter, registered debounced level and one-cycle rise/fall pulses.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   raw_i    : asynchronous raw input
//   en_i     : enable; 0 freezes the channel (FSM forced to STABLE)
//   db_o     : debounced level
//   rise_o   : one-cycle pulse on committed 0->1
//   fall_o   : one-cycle pulse on committed 1->0
//   busy_o   : channel currently in COUNT
//
// state     | meaning
// ST_STABLE | db_o matches the synchronized input (or channel disabled)
// ST_COUNT  | synchronized input differs from db_o, counting stable cycles
module gin_debounce_ch
   import gin_debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   input  logic en_i,
   output logic db_o,
   output logic rise_o,
   output logic fall_o,
   output logic busy_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1_q, s2_q;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_q, db_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             commit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= ST_STABLE;
         cnt_q   <= '0;
         db_q    <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         s1_q    <= raw_i;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      commit  = 1'b0;

      if (!en_i) begin
         state_d = ST_STABLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_STABLE: begin
               if (s2_q != db_q) begin
                  // A single required cycle means the first differing sample is enough.
                  if (STABLE_CYCLES == 1) begin
                     commit = 1'b1;
                  end else begin
                     state_d = ST_COUNT;
                     cnt_d   = CNT_ONE;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            ST_COUNT: begin
               if (s2_q == db_q) begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  commit = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end
         endcase
      end

      if (commit) begin
         db_d    = s2_q;
         cnt_d   = '0;
         state_d = ST_STABLE;
         rise_d  = s2_q;
         fall_d  = ~s2_q;
      end
   end

   // state_q is the registered next state, so this is busy in registered form.
   assign busy_o = (state_q == ST_COUNT);
   assign db_o   = db_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/gin_debounce.sv
// Multi-channel input debouncer feeding the combinational gate blocks.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   raw_in  : asynchronous raw inputs, one per channel
//   en      : debounce enable; 0 freezes all channels
//   db_out  : debounced levels (db_out[0] -> gor.a, db_out[1] -> gor.b)
//   rise    : per-channel one-cycle pulse on committed 0->1
//   fall    : per-channel one-cycle pulse on committed 1->0
//   busy    : any channel currently counting
module gin_debounce
   import gin_debounce_pkg::*;
#(
   parameter int WIDTH         = 2,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] raw_in,
   input  logic             en,
   output logic [WIDTH-1:0] db_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             busy
);

   logic [WIDTH-1:0] busy_ch;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      gin_debounce_ch #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .CNT_W         (CNT_W)
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .raw_i  (raw_in[i]),
         .en_i   (en),
         .db_o   (db_out[i]),
         .rise_o (rise[i]),
         .fall_o (fall[i]),
         .busy_o (busy_ch[i])
      );
   end

   assign busy = |busy_ch;

endmodule
